// File: rtl/midi_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : midi_uart_rx
// Description : MIDI input deserializer. 8N1 UART receiver (31250 baud at
//               CLKS_PER_BIT clocks per bit) for one synchronized MIDI line.
//               Holds one received byte behind a valid/ready handshake and
//               flags framing errors and overruns with one-cycle pulses.
// Ports       : clk        system clock, rising edge
//               rst        asynchronous, active-low reset
//               rx         synchronized MIDI line, idle high
//               rx_data    received byte, stable while rx_valid is high
//               rx_valid   byte available in output register
//               rx_ready   consumer accepts byte when rx_valid && rx_ready
//               frame_err  1-cycle pulse: stop bit sampled low
//               overrun    1-cycle pulse: good byte dropped, register full
//               busy       high whenever the receiver is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module midi_uart_rx #(
  parameter int CLKS_PER_BIT = 384
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  // The counter restarts at 0 on the cycle after each sample, so a sample
  // interval of N cycles ends when the counter reaches N-1.
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic [7:0]    data_nxt;
  logic          valid_nxt;
  logic          ferr_nxt;
  logic          ovr_nxt;
  logic          pop;

  assign pop  = rx_valid && rx_ready;
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      shift     <= shift_nxt;
      rx_data   <= data_nxt;
      rx_valid  <= valid_nxt;
      frame_err <= ferr_nxt;
      overrun   <= ovr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    data_nxt    = rx_data;
    valid_nxt   = rx_valid && !rx_ready;
    ferr_nxt    = 1'b0;
    ovr_nxt     = 1'b0;

    case (state)
      S_IDLE: begin
        if (!rx) begin
          state_nxt = S_START;
          cnt_nxt   = '0;
        end
      end

      S_START: begin
        if (cnt == CNT_HALF) begin
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          // A start bit that is already high again at mid-bit was a glitch.
          state_nxt   = rx ? S_IDLE : S_DATA;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      S_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          shift_nxt = {rx, shift[7:1]};  // LSB arrives first
          if (bit_idx == 3'd7) begin
            state_nxt = S_STOP;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      S_STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          if (rx) begin
            // Leaving at mid-stop keeps half a bit of resync margin.
            state_nxt = S_IDLE;
            if (!rx_valid || pop) begin
              data_nxt  = shift;
              valid_nxt = 1'b1;
            end else begin
              ovr_nxt = 1'b1;
            end
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = S_BREAK;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      S_BREAK: begin
        // Line held low (break or misframe): wait for idle before rearming.
        if (rx) begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_midi_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_midi_uart_rx
// Description : Self-checking bench for midi_uart_rx with CLKS_PER_BIT=16.
//               A frame-timing model predicts every output each cycle;
//               directed scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_midi_uart_rx;

  localparam int C    = 16;
  localparam int HALF = C / 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  midi_uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Edge counter used for latency measurements.
  int unsigned ecount = 0;
  always @(posedge clk) ecount <= ecount + 1;

  // ------------------------------------------------------------------
  // Model: frame timing computed from the start-edge cycle with plain
  // arithmetic (sample k = HALF + i*C edges after the start edge).
  // ------------------------------------------------------------------
  int          mode = 0;      // 0 idle, 1 in frame, 2 waiting for line high
  int unsigned mcnt = 0;
  int unsigned t0   = 0;
  logic [7:0]  msh  = '0;
  logic        m_valid = 1'b0;
  logic [7:0]  m_data  = '0;
  logic        m_ferr  = 1'b0;
  logic        m_ovr   = 1'b0;

  task automatic model_step();
    logic pop, nv;
    int   k, i;
    if (!rst) begin
      mode = 0; m_valid = 1'b0; m_data = 8'h00; m_ferr = 1'b0; m_ovr = 1'b0;
    end else begin
      pop    = m_valid && rx_ready;
      nv     = m_valid && !rx_ready;
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      case (mode)
        0: if (rx == 1'b0) begin mode = 1; t0 = mcnt; end
        1: begin
          k = int'(mcnt - t0);
          if (k == HALF) begin
            if (rx) mode = 0;
          end else if (k > HALF && ((k - HALF) % C) == 0) begin
            i = (k - HALF) / C;
            if (i <= 8) msh[i-1] = rx;
            else if (rx) begin
              mode = 0;
              if (!m_valid || pop) begin nv = 1'b1; m_data = msh; end
              else m_ovr = 1'b1;
            end else begin
              mode = 2; m_ferr = 1'b1;
            end
          end
        end
        default: if (rx) mode = 0;
      endcase
      m_valid = nv;
      mcnt++;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    model_step();
  end

  // Event tallies for the directed checks.
  int          n_valid = 0, n_ferr = 0, n_ovr = 0;
  logic [7:0]  v_data = '0;
  int unsigned v_edge = 0;
  logic        pv = 1'b0;

  initial forever begin
    @(negedge clk);
    chk("outputs", {20'd0, busy, overrun, frame_err, rx_valid, rx_data},
                   {20'd0, (mode != 0), m_ovr, m_ferr, m_valid, m_data});
    chk("ferr_ovr_exclusive", {31'd0, frame_err & overrun}, 32'd0);
    if (rx_valid && !pv) begin n_valid++; v_data = rx_data; v_edge = ecount; end
    pv = rx_valid;
    if (frame_err) n_ferr++;
    if (overrun)   n_ovr++;
  end

  task automatic clear();
    n_valid = 0; n_ferr = 0; n_ovr = 0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop, input bit pulse_ready);
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (C) @(negedge clk);
    end
    rx = stop;
    if (pulse_ready) begin
      // Ready high for exactly the stop-sample edge.
      repeat (HALF) @(negedge clk);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      repeat (C - HALF - 1) @(negedge clk);
    end else begin
      repeat (C) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  int unsigned s;
  logic [7:0]  aa;

  initial begin
    // Reset values
    settle(3);
    chk("reset_valid", {31'd0, rx_valid}, 32'd0);
    chk("reset_data", {24'd0, rx_data}, 32'h00);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_flags", {30'd0, frame_err, overrun}, 32'd0);
    rst = 1'b1;
    settle(3);

    // Single byte and latency
    clear();
    s = ecount;
    send_byte(8'h90, 1'b1, 1'b0);
    settle(20);
    chk("t1_nvalid", n_valid, 32'd1);
    chk("t1_data", {24'd0, v_data}, 32'h90);
    chk("t1_latency", v_edge - s, 32'd153);
    chk("t1_flags", n_ferr + n_ovr, 32'd0);

    // Start glitch
    clear();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    settle(30);
    chk("t2_events", n_valid + n_ferr + n_ovr, 32'd0);
    chk("t2_busy", {31'd0, busy}, 32'd0);

    // Framing error, break, recovery
    clear();
    send_byte(8'h3C, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    chk("t3_busy_in_break", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    settle(5);
    chk("t3_busy_after", {31'd0, busy}, 32'd0);
    chk("t3_nferr", n_ferr, 32'd1);
    chk("t3_nvalid", n_valid, 32'd0);
    send_byte(8'hF8, 1'b1, 1'b0);
    settle(20);
    chk("t3_f8_nvalid", n_valid, 32'd1);
    chk("t3_f8_data", {24'd0, v_data}, 32'hF8);

    // Overruns while the consumer stalls
    rx_ready = 1'b0;
    clear();
    send_byte(8'h90, 1'b1, 1'b0);
    send_byte(8'h45, 1'b1, 1'b0);
    send_byte(8'h7F, 1'b1, 1'b0);
    settle(5);
    chk("t4_valid", {31'd0, rx_valid}, 32'd1);
    chk("t4_data", {24'd0, rx_data}, 32'h90);
    chk("t4_novr", n_ovr, 32'd2);
    rx_ready = 1'b1;
    settle(1);
    chk("t4_popped", {31'd0, rx_valid}, 32'd0);
    rx_ready = 1'b0;

    // Pop and load on the same cycle
    clear();
    send_byte(8'hB0, 1'b1, 1'b0);
    settle(5);
    chk("t5_hold_data", {24'd0, rx_data}, 32'hB0);
    send_byte(8'h07, 1'b1, 1'b1);
    settle(5);
    chk("t5_valid", {31'd0, rx_valid}, 32'd1);
    chk("t5_data", {24'd0, rx_data}, 32'h07);
    chk("t5_novr", n_ovr, 32'd0);
    rx_ready = 1'b1;
    settle(2);
    chk("t5_drained", {31'd0, rx_valid}, 32'd0);

    // Reset in the middle of a byte
    aa = 8'hAA;
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = aa[i];
      if (i == 2) begin
        repeat (HALF) @(negedge clk);
        #3 rst = 1'b0;
        #1;
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_data", {24'd0, rx_data}, 32'h00);
        chk("t6_rst_valid_flags", {29'd0, rx_valid, frame_err, overrun}, 32'd0);
        repeat (C - HALF) @(negedge clk);
      end else if (i == 7) begin
        repeat (HALF) @(negedge clk);
        #3 rst = 1'b1;
        repeat (C - HALF) @(negedge clk);
      end else begin
        repeat (C) @(negedge clk);
      end
    end
    rx = 1'b1;
    repeat (C) @(negedge clk);
    clear();
    settle(20);
    chk("t6_no_byte", n_valid + n_ferr + n_ovr, 32'd0);
    send_byte(8'h55, 1'b1, 1'b0);
    settle(20);
    chk("t6_55_nvalid", n_valid, 32'd1);
    chk("t6_55_data", {24'd0, v_data}, 32'h55);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
